// File: rtl/cook_timer.sv
// Microwave cook-time countdown: BCD MM:SS entry, 1 Hz countdown from clk,
// magnetron gating and a timed done level that enables the downstream buzzer.
module cook_timer #(
    parameter int         CLK_HZ      = 100_000_000,
    parameter int         DONE_HOLD_S = 4,
    parameter logic [7:0] QUICK_SEC   = 8'h30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       add_min,
    input  logic       add_sec10,
    input  logic       start,
    input  logic       stop_clr,
    input  logic       door_open,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       magnetron,
    output logic       done
);

    localparam int HOLD_CYC = DONE_HOLD_S * CLK_HZ;
    localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre, pre_nx;
    logic [HW-1:0] hold, hold_nx;
    logic [7:0]    min_nx, sec_nx;
    logic          running_nx, done_nx;
    logic          tick, time_zero;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign tick      = (state == S_RUN) && (pre == PRE_LAST);
    assign time_zero = (min_bcd == 8'h00) && (sec_bcd == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            pre     <= '0;
            hold    <= '0;
            min_bcd <= 8'h00;
            sec_bcd <= 8'h00;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            pre     <= pre_nx;
            hold    <= hold_nx;
            min_bcd <= min_nx;
            sec_bcd <= sec_nx;
            running <= running_nx;
            done    <= done_nx;
        end
    end

    // Prescaler and hold counter default to 0 so they only run in their own state.
    always_comb begin
        state_nx = state;
        min_nx   = min_bcd;
        sec_nx   = sec_bcd;
        pre_nx   = '0;
        hold_nx  = '0;
        case (state)
            S_IDLE, S_PAUSE: begin
                if (stop_clr) begin
                    min_nx   = 8'h00;
                    sec_nx   = 8'h00;
                    state_nx = S_IDLE;
                end else if (start) begin
                    if (!door_open) begin
                        state_nx = S_RUN;
                        if (time_zero) sec_nx = QUICK_SEC;
                    end
                end else if (add_sec10) begin
                    if (sec_bcd[7:4] >= 4'd5) begin
                        if (min_bcd == 8'h99) begin
                            sec_nx = 8'h59;
                        end else begin
                            sec_nx = {sec_bcd[7:4] - 4'd5, sec_bcd[3:0]};
                            min_nx = bcd_inc(min_bcd);
                        end
                    end else begin
                        sec_nx = {sec_bcd[7:4] + 4'd1, sec_bcd[3:0]};
                    end
                end else if (add_min) begin
                    if (min_bcd != 8'h99) min_nx = bcd_inc(min_bcd);
                end
            end
            S_RUN: begin
                if (door_open || stop_clr) begin
                    state_nx = S_PAUSE;
                end else begin
                    pre_nx = tick ? '0 : pre + PW'(1);
                    if (tick) begin
                        if (min_bcd == 8'h00 && sec_bcd <= 8'h01) begin
                            sec_nx   = 8'h00;
                            state_nx = S_DONE;
                        end else if (sec_bcd == 8'h00) begin
                            sec_nx = 8'h59;
                            min_nx = bcd_dec(min_bcd);
                        end else begin
                            sec_nx = bcd_dec(sec_bcd);
                        end
                    end
                end
            end
            S_DONE: begin
                min_nx = 8'h00;
                sec_nx = 8'h00;
                if (door_open || stop_clr || hold == HOLD_LAST) state_nx = S_IDLE;
                else hold_nx = hold + HW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        running_nx = (state_nx == S_RUN);
        done_nx    = (state_nx == S_DONE);
        magnetron  = running & ~door_open;
    end

endmodule
